// File: rtl/sdram_pkg.sv
// Shared SDRAM controller definitions: command encodings, constant bank/address
// buses and the refresh scheduler state type.
package sdram_pkg;

   // {CS#,RAS#,CAS#,WE#}
   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_AR  = 4'b0001;

   localparam logic [15:0] BANK_ONES = '1;
   localparam logic [31:0] ADDR_ONES = '1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_PRE,
      ST_TRP,
      ST_AR,
      ST_TRFC,
      ST_END
   } ref_state_e;

endpackage

// File: rtl/sdram_ref_timer.sv
// Refresh interval counter: counts 0..TREFI_CYC-1 while enabled and pulses
// tick for one cycle on the wrap.
module sdram_ref_timer #(
   parameter int TREFI_CYC = 780
) (
   input  logic ar_clk,
   input  logic ar_rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW   = (TREFI_CYC > 1) ? $clog2(TREFI_CYC) : 1;
   localparam logic [CW-1:0] LAST = CW'(TREFI_CYC - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      tick  = 1'b0;
      if (en) begin
         if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) cnt_q <= '0;
      else           cnt_q <= cnt_d;
   end

endmodule

// File: rtl/sdram_refresh_sched.sv
// Auto-refresh scheduler: accumulates refresh debt at tREFI and, when granted,
// issues PRE-all followed by up to AR_BURST AUTO REFRESH commands.
module sdram_refresh_sched
   import sdram_pkg::*;
#(
   parameter int CLK_MHZ    = 100,
   parameter int TREFI_NS   = 7800,
   parameter int TRP_CYC    = 2,
   parameter int TRFC_CYC   = 7,
   parameter int AR_BURST   = 2,
   parameter int MAX_DEBT   = 8,
   parameter int URGENT_LVL = 6,
   parameter int ADDR_W     = 13,
   parameter int BANK_W     = 2
) (
   input  logic                             ar_clk,
   input  logic                             ar_rst_n,
   input  logic                             init_end,
   input  logic                             ar_en,
   output logic [3:0]                       ar_cmd,
   output logic [BANK_W-1:0]                ar_bank,
   output logic [ADDR_W-1:0]                ar_addr,
   output logic                             ar_req,
   output logic                             ar_urgent,
   output logic                             ar_end,
   output logic [$clog2(MAX_DEBT+1)-1:0]    ar_debt,
   output logic                             ar_ovf,
   output ref_state_e                       dbg_state
);

   localparam int TREFI_CYC = CLK_MHZ * TREFI_NS / 1000;
   localparam int DW        = $clog2(MAX_DEBT + 1);
   localparam int NW        = $clog2(AR_BURST + 1);
   localparam int WMAX      = (TRP_CYC > TRFC_CYC) ? TRP_CYC : TRFC_CYC;
   localparam int WW        = $clog2(WMAX + 1);
   // Wait states last N-1 cycles; the counter starts at 0 on entry.
   localparam int TRP_LAST  = (TRP_CYC > 1) ? TRP_CYC - 2 : 0;
   localparam int TRFC_LAST = (TRFC_CYC > 1) ? TRFC_CYC - 2 : 0;

   ref_state_e    state_q, state_d;
   logic [DW-1:0] debt_q, debt_d;
   logic          ovf_q, ovf_d;
   logic [NW-1:0] n_q, n_d;
   logic [NW-1:0] issued_q, issued_d;
   logic [WW-1:0] wait_q, wait_d;
   logic [3:0]    cmd_q, cmd_d;
   logic          end_q, end_d;
   logic          tick;
   logic          ar_issue;

   sdram_ref_timer #(
      .TREFI_CYC (TREFI_CYC)
   ) u_timer (
      .ar_clk   (ar_clk),
      .ar_rst_n (ar_rst_n),
      .en       (init_end),
      .tick     (tick)
   );

   assign ar_issue = (state_q == ST_AR);
   assign ar_req   = (state_q == ST_IDLE) && (debt_q != '0) && init_end;

   // A tick and an AR in the same cycle cancel; a tick at saturation is lost and flagged.
   always_comb begin
      debt_d = debt_q;
      ovf_d  = ovf_q;
      if (tick && !ar_issue) begin
         if (debt_q == DW'(MAX_DEBT)) ovf_d = 1'b1;
         else                         debt_d = debt_q + 1'b1;
      end else if (!tick && ar_issue && (debt_q != '0)) begin
         debt_d = debt_q - 1'b1;
      end
   end

   always_comb begin
      state_d  = state_q;
      n_d      = n_q;
      issued_d = issued_q;
      case (state_q)
         ST_IDLE: begin
            if (ar_en && ar_req) begin
               state_d  = ST_PRE;
               issued_d = '0;
               if (int'(debt_q) >= AR_BURST) n_d = NW'(AR_BURST);
               else                          n_d = NW'(debt_q);
            end
         end
         ST_PRE:  state_d = (TRP_CYC > 1) ? ST_TRP : ST_AR;
         ST_TRP:  if (wait_q == WW'(TRP_LAST)) state_d = ST_AR;
         ST_AR: begin
            issued_d = issued_q + 1'b1;
            if (TRFC_CYC > 1)        state_d = ST_TRFC;
            else if (issued_d < n_q) state_d = ST_AR;
            else                     state_d = ST_END;
         end
         ST_TRFC: begin
            if (wait_q == WW'(TRFC_LAST)) state_d = (issued_q < n_q) ? ST_AR : ST_END;
         end
         ST_END:  state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_comb begin
      wait_d = '0;
      if ((state_d == state_q) && ((state_q == ST_TRP) || (state_q == ST_TRFC)))
         wait_d = wait_q + 1'b1;
   end

   // Command outputs are registered from next-state so they line up with state_q.
   always_comb begin
      cmd_d = CMD_NOP;
      if (state_d == ST_PRE)     cmd_d = CMD_PRE;
      else if (state_d == ST_AR) cmd_d = CMD_AR;
      end_d = (state_d == ST_END);
   end

   always_ff @(posedge ar_clk or negedge ar_rst_n) begin
      if (!ar_rst_n) begin
         state_q  <= ST_IDLE;
         debt_q   <= '0;
         ovf_q    <= 1'b0;
         n_q      <= '0;
         issued_q <= '0;
         wait_q   <= '0;
         cmd_q    <= CMD_NOP;
         end_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         debt_q   <= debt_d;
         ovf_q    <= ovf_d;
         n_q      <= n_d;
         issued_q <= issued_d;
         wait_q   <= wait_d;
         cmd_q    <= cmd_d;
         end_q    <= end_d;
      end
   end

   assign ar_cmd    = cmd_q;
   assign ar_end    = end_q;
   assign ar_debt   = debt_q;
   assign ar_ovf    = ovf_q;
   assign ar_urgent = (int'(debt_q) >= URGENT_LVL);
   assign ar_bank   = BANK_ONES[BANK_W-1:0];
   assign ar_addr   = ADDR_ONES[ADDR_W-1:0];
   assign dbg_state = state_q;

endmodule

// File: tb/tb_sdram_refresh_sched.sv
// Directed bench for sdram_refresh_sched at default parameters (tREFI = 780 cycles).
module tb_sdram_refresh_sched;
   import sdram_pkg::*;

   logic        ar_clk = 1'b0;
   logic        ar_rst_n;
   logic        init_end;
   logic        ar_en;
   logic [3:0]  ar_cmd;
   logic [1:0]  ar_bank;
   logic [12:0] ar_addr;
   logic        ar_req;
   logic        ar_urgent;
   logic        ar_end;
   logic [3:0]  ar_debt;
   logic        ar_ovf;
   ref_state_e  dbg_state;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   sdram_refresh_sched dut (
      .ar_clk    (ar_clk),
      .ar_rst_n  (ar_rst_n),
      .init_end  (init_end),
      .ar_en     (ar_en),
      .ar_cmd    (ar_cmd),
      .ar_bank   (ar_bank),
      .ar_addr   (ar_addr),
      .ar_req    (ar_req),
      .ar_urgent (ar_urgent),
      .ar_end    (ar_end),
      .ar_debt   (ar_debt),
      .ar_ovf    (ar_ovf),
      .dbg_state (dbg_state)
   );

   always #5 ar_clk = ~ar_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Advance n rising edges and settle 1ns past the last one.
   task automatic step(input int n);
      repeat (n) @(posedge ar_clk);
      #1;
      cyc += n;
   endtask

   task automatic reset_dut();
      ar_rst_n = 1'b0;
      step(3);
      ar_rst_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      int n_cmd;
      int n_req;
      int n_end;
      int exp_d;

      ar_rst_n = 1'b0;
      init_end = 1'b0;
      ar_en    = 1'b0;

      // Reset values
      step(3);
      chk("rst_cmd",    ar_cmd,    CMD_NOP);
      chk("rst_bank",   ar_bank,   2'b11);
      chk("rst_addr",   ar_addr,   13'h1fff);
      chk("rst_req",    ar_req,    0);
      chk("rst_urgent", ar_urgent, 0);
      chk("rst_end",    ar_end,    0);
      chk("rst_debt",   ar_debt,   0);
      chk("rst_ovf",    ar_ovf,    0);
      chk("rst_state",  dbg_state, ST_IDLE);

      // Initialisation gating: no ticks and no commands while init_end is low
      ar_rst_n = 1'b1;
      ar_en    = 1'b1;
      n_cmd    = 0;
      n_req    = 0;
      for (int i = 0; i < 2000; i++) begin
         step(1);
         if (ar_cmd !== CMD_NOP) n_cmd++;
         if (ar_req !== 1'b0)    n_req++;
      end
      chk("gate_cmd_cycles", n_cmd,     0);
      chk("gate_req_cycles", n_req,     0);
      chk("gate_debt",       ar_debt,   0);
      chk("gate_state",      dbg_state, ST_IDLE);
      ar_en = 1'b0;

      // Single refresh: first tick 780 edges after init_end, grant at edge k=781
      init_end = 1'b1;
      reset_dut();
      step(779);
      chk("s_debt_pre_tick", ar_debt, 0);
      chk("s_req_pre_tick",  ar_req,  0);
      step(1);
      chk("s_debt_tick", ar_debt, 1);
      chk("s_req_tick",  ar_req,  1);
      ar_en = 1'b1;
      step(1);
      chk("s_cmd_k1",   ar_cmd,    CMD_PRE);
      chk("s_state_k1", dbg_state, ST_PRE);
      chk("s_req_k1",   ar_req,    0);
      ar_en = 1'b0;
      step(1);
      chk("s_cmd_k2",   ar_cmd,    CMD_NOP);
      chk("s_state_k2", dbg_state, ST_TRP);
      step(1);
      chk("s_cmd_k3",  ar_cmd,  CMD_AR);
      chk("s_debt_k3", ar_debt, 1);
      step(1);
      chk("s_cmd_k4",  ar_cmd,  CMD_NOP);
      chk("s_debt_k4", ar_debt, 0);
      step(5);
      chk("s_end_k9",   ar_end,    0);
      chk("s_state_k9", dbg_state, ST_TRFC);
      step(1);
      chk("s_end_k10",   ar_end,    1);
      chk("s_state_k10", dbg_state, ST_END);
      chk("s_cmd_k10",   ar_cmd,    CMD_NOP);
      step(1);
      chk("s_end_k11",   ar_end,    0);
      chk("s_state_k11", dbg_state, ST_IDLE);
      chk("s_req_k11",   ar_req,    0);
      chk("s_debt_k11",  ar_debt,   0);

      // Idle accumulation: nine intervals, saturate at 8, overflow on the ninth
      reset_dut();
      for (int i = 1; i <= 9; i++) begin
         step(779);
         exp_d = (i - 1 > 8) ? 8 : i - 1;
         chk($sformatf("acc_debt_before_%0d", i), ar_debt, exp_d);
         step(1);
         exp_d = (i > 8) ? 8 : i;
         chk($sformatf("acc_debt_%0d",   i), ar_debt,   exp_d);
         chk($sformatf("acc_urgent_%0d", i), ar_urgent, (exp_d >= 6) ? 1 : 0);
         chk($sformatf("acc_ovf_%0d",    i), ar_ovf,    (i == 9) ? 1 : 0);
         chk($sformatf("acc_req_%0d",    i), ar_req,    1);
      end

      // Burst with residual debt: debt 5, grant at edge k=3901
      reset_dut();
      step(3900);
      chk("b_debt_start", ar_debt,   5);
      chk("b_urgent",     ar_urgent, 0);
      ar_en = 1'b1;
      step(1);
      chk("b_cmd_k1", ar_cmd, CMD_PRE);
      ar_en = 1'b0;
      step(2);
      chk("b_cmd_k3",  ar_cmd,  CMD_AR);
      chk("b_debt_k3", ar_debt, 5);
      step(1);
      chk("b_debt_k4", ar_debt, 4);
      step(6);
      chk("b_cmd_k10", ar_cmd, CMD_AR);
      step(1);
      chk("b_debt_k11", ar_debt, 3);
      step(5);
      chk("b_end_k16", ar_end, 0);
      step(1);
      chk("b_end_k17",   ar_end,    1);
      chk("b_state_k17", dbg_state, ST_END);
      chk("b_debt_k17",  ar_debt,   3);
      step(1);
      chk("b_state_k18", dbg_state, ST_IDLE);
      chk("b_req_k18",   ar_req,    1);
      chk("b_end_k18",   ar_end,    0);

      // Coincident tick: grant at edge 4677 puts the first AR's edge on tick edge 4680
      step(4676 - cyc);
      ar_en = 1'b1;
      step(1);
      chk("c_cmd_k1", ar_cmd, CMD_PRE);
      ar_en = 1'b0;
      step(2);
      chk("c_cmd_k3",  ar_cmd,  CMD_AR);
      chk("c_debt_k3", ar_debt, 3);
      step(1);
      chk("c_debt_after_coincident", ar_debt, 3);
      chk("c_ovf",                   ar_ovf,  0);
      step(6);
      chk("c_cmd_k10",  ar_cmd,  CMD_AR);
      chk("c_debt_k10", ar_debt, 3);
      step(1);
      chk("c_debt_k11", ar_debt, 2);
      step(6);
      chk("c_end_k17",  ar_end,  1);
      chk("c_debt_k17", ar_debt, 2);
      step(1);
      chk("c_state_k18", dbg_state, ST_IDLE);
      chk("c_req_k18",   ar_req,    1);

      // Reset mid-sequence during TRFC
      ar_en = 1'b1;
      step(1);
      chk("r_state_k1", dbg_state, ST_PRE);
      ar_en = 1'b0;
      step(3);
      chk("r_state_k4", dbg_state, ST_TRFC);
      chk("r_debt_k4",  ar_debt,   1);
      #2;
      ar_rst_n = 1'b0;
      #1;
      chk("r_cmd_async",   ar_cmd,    CMD_NOP);
      chk("r_debt_async",  ar_debt,   0);
      chk("r_state_async", dbg_state, ST_IDLE);
      chk("r_end_async",   ar_end,    0);
      chk("r_req_async",   ar_req,    0);
      n_end = 0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         if (ar_end !== 1'b0) n_end++;
      end
      ar_rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         if (ar_end !== 1'b0) n_end++;
      end
      chk("r_end_cycles", n_end,   0);
      chk("r_ovf_after",  ar_ovf,  0);
      chk("r_cmd_after",  ar_cmd,  CMD_NOP);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
